// File: rtl/ccu_conflict_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ccu_conflict_arbiter
// Purpose  : Address-conflict-aware round-robin admission arbiter with a
//            starvation lock, sitting in front of the shared CCU request path.
// Revision : 1.0
// ============================================================================
module ccu_conflict_arbiter #(
    parameter int NoPorts      = 4,
    parameter int AxiAddrWidth = 64,
    parameter int MaxWait      = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NoPorts-1:0]              req_valid_i,
    input  logic [NoPorts-1:0]              req_write_i,
    input  logic [NoPorts*AxiAddrWidth-1:0] req_addr_i,
    input  logic [NoPorts*8-1:0]            req_len_i,
    input  logic [NoPorts*3-1:0]            req_size_i,
    output logic [NoPorts-1:0]              req_ready_o,
    input  logic [NoPorts-1:0]              wr_done_i,
    input  logic [NoPorts-1:0]              rd_done_i,
    output logic                            lock_o,
    output logic [$clog2(NoPorts)-1:0]      lock_idx_o
);

    localparam int c_IDX_W = $clog2(NoPorts);
    // One extra bit so the exclusive end of a range at the top of memory never wraps.
    localparam int c_RW    = AxiAddrWidth + 1;
    localparam int c_CNT_W = $clog2(MaxWait + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MaxWait);

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_IDX_W-1:0]   r_lock_idx, w_lock_idx_nxt;
    logic [c_IDX_W-1:0]   r_rr;
    logic [c_CNT_W-1:0]   r_cnt [NoPorts];

    logic [NoPorts-1:0]   r_wr_vld, r_rd_vld;
    logic [c_RW-1:0]      r_wr_start [NoPorts];
    logic [c_RW-1:0]      r_wr_end   [NoPorts];
    logic [c_RW-1:0]      r_rd_start [NoPorts];
    logic [c_RW-1:0]      r_rd_end   [NoPorts];

    logic [c_RW-1:0]      w_start [NoPorts];
    logic [c_RW-1:0]      w_end   [NoPorts];
    logic [NoPorts-1:0]   w_elig;
    logic [NoPorts-1:0]   w_grant;
    logic [NoPorts-1:0]   w_hs;
    logic [c_IDX_W-1:0]   w_gidx;
    logic                 w_sat_found;
    logic [c_IDX_W-1:0]   w_sat_idx;

    function automatic logic f_overlap(input logic [c_RW-1:0] a_s, input logic [c_RW-1:0] a_e,
                                       input logic [c_RW-1:0] b_s, input logic [c_RW-1:0] b_e);
        return (a_s < b_e) && (b_s < a_e);
    endfunction

    function automatic logic [c_IDX_W-1:0] f_wrap(input logic [c_IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NoPorts) s = s - NoPorts;
        return c_IDX_W'(s);
    endfunction

    for (genvar p = 0; p < NoPorts; p++) begin : g_range
        logic [AxiAddrWidth-1:0] w_addr;
        logic [AxiAddrWidth-1:0] w_mask;
        logic [2:0]              w_size;
        logic [8:0]              w_beats;
        assign w_addr     = req_addr_i[p*AxiAddrWidth +: AxiAddrWidth];
        assign w_size     = req_size_i[p*3 +: 3];
        assign w_beats    = {1'b0, req_len_i[p*8 +: 8]} + 9'd1;
        assign w_mask     = ~((AxiAddrWidth'(1) << w_size) - AxiAddrWidth'(1));
        assign w_start[p] = {1'b0, w_addr & w_mask};
        assign w_end[p]   = w_start[p] + (c_RW'(w_beats) << w_size);
    end

    for (genvar i = 0; i < NoPorts; i++) begin : g_elig
        logic w_hit;
        always_comb begin
            w_hit = 1'b0;
            for (int j = 0; j < NoPorts; j++) begin
                if (j != i) begin
                    if (r_wr_vld[j] && f_overlap(w_start[i], w_end[i], r_wr_start[j], r_wr_end[j]))
                        w_hit = 1'b1;
                    // Reads may share bytes with other reads; only writes see read slots.
                    if (req_write_i[i] && r_rd_vld[j] &&
                        f_overlap(w_start[i], w_end[i], r_rd_start[j], r_rd_end[j]))
                        w_hit = 1'b1;
                end
            end
        end
        assign w_elig[i] = req_valid_i[i] & ~w_hit &
                           (req_write_i[i] ? ~r_wr_vld[i] : ~r_rd_vld[i]);
    end

    always_comb begin
        w_grant = '0;
        w_gidx  = r_lock_idx;
        if (r_state == ST_LOCK) begin
            w_grant[r_lock_idx] = w_elig[r_lock_idx];
        end else begin
            // Walk downward so the nearest eligible port after rr_ptr wins.
            for (int k = NoPorts - 1; k >= 0; k--) begin
                if (w_elig[f_wrap(r_rr, k)]) w_gidx = f_wrap(r_rr, k);
            end
            w_grant[w_gidx] = w_elig[w_gidx];
        end
    end

    assign req_ready_o = w_grant & {NoPorts{rst_ni}};
    assign w_hs        = req_valid_i & req_ready_o;

    always_comb begin
        w_sat_found = 1'b0;
        w_sat_idx   = '0;
        for (int i = NoPorts - 1; i >= 0; i--) begin
            if (r_cnt[i] == c_MAX_CNT) begin
                w_sat_found = 1'b1;
                w_sat_idx   = c_IDX_W'(i);
            end
        end
        w_state_nxt    = r_state;
        w_lock_idx_nxt = r_lock_idx;
        case (r_state)
            ST_ARB: begin
                if (w_sat_found) begin
                    w_state_nxt    = ST_LOCK;
                    w_lock_idx_nxt = w_sat_idx;
                end
            end
            ST_LOCK: begin
                if (w_hs[r_lock_idx] || !req_valid_i[r_lock_idx]) begin
                    w_state_nxt    = ST_ARB;
                    w_lock_idx_nxt = '0;
                end
            end
            default: begin
                w_state_nxt    = ST_ARB;
                w_lock_idx_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_ARB;
            r_lock_idx <= '0;
            r_rr       <= '0;
            r_wr_vld   <= '0;
            r_rd_vld   <= '0;
            for (int i = 0; i < NoPorts; i++) begin
                r_cnt[i]      <= '0;
                r_wr_start[i] <= '0;
                r_wr_end[i]   <= '0;
                r_rd_start[i] <= '0;
                r_rd_end[i]   <= '0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_lock_idx <= w_lock_idx_nxt;
            if (|w_hs) r_rr <= f_wrap(w_gidx, 1);
            for (int i = 0; i < NoPorts; i++) begin
                if (w_hs[i] && req_write_i[i]) begin
                    r_wr_vld[i]   <= 1'b1;
                    r_wr_start[i] <= w_start[i];
                    r_wr_end[i]   <= w_end[i];
                end else if (wr_done_i[i]) begin
                    r_wr_vld[i]   <= 1'b0;
                end
                if (w_hs[i] && !req_write_i[i]) begin
                    r_rd_vld[i]   <= 1'b1;
                    r_rd_start[i] <= w_start[i];
                    r_rd_end[i]   <= w_end[i];
                end else if (rd_done_i[i]) begin
                    r_rd_vld[i]   <= 1'b0;
                end
                if (req_valid_i[i] && !w_hs[i])
                    r_cnt[i] <= (r_cnt[i] == c_MAX_CNT) ? r_cnt[i] : r_cnt[i] + c_CNT_W'(1);
                else
                    r_cnt[i] <= '0;
            end
        end
    end

    assign lock_o     = (r_state == ST_LOCK);
    assign lock_idx_o = r_lock_idx;

endmodule
`default_nettype wire
